// File: rtl/cmd_pkg.sv
// Shared definitions for the command register-access stage: command word
// field positions, command type codes and FSM state encodings.
package cmd_pkg;

  localparam int CMD_W    = 64;
  localparam int TYPE_HI  = 63;
  localparam int TYPE_LO  = 61;
  localparam int SUCC_BIT = 60;
  localparam int WR_BIT   = 59;
  localparam int MDID_HI  = 58;
  localparam int MDID_LO  = 52;
  localparam int ADDR_HI  = 51;
  localparam int ADDR_LO  = 32;
  localparam int DATA_HI  = 31;
  localparam int DATA_LO  = 0;

  typedef enum logic [2:0] {
    TYPE_HEAD      = 3'b101,
    TYPE_BODY      = 3'b111,
    TYPE_TAIL      = 3'b110,
    TYPE_HEAD_TAIL = 3'b100
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_SEND    = 2'd3
  } state_e;

endpackage

// File: rtl/cmd_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: the head word is always visible
// on rd_data while the FIFO is not empty; rd_en pops it.
module cmd_fifo_fwft #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      used
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH[AW:0]);
  assign used    = count_reg;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg];

  // Storage: only written on an accepted push, so it needs no reset
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers and occupancy; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/cmd_reg_access.sv
// Config-path stage: commands addressed to this MDID are executed on the
// local register bus and returned with status/data filled in; all other
// commands are forwarded unchanged. One command per 3 cycles at most.
// Optional statistics counters are enabled with CMD_REG_ACCESS_STAT_EN.
module cmd_reg_access
  import cmd_pkg::*;
#(
  parameter logic [6:0]  MDID       = 7'd1,
  parameter logic [19:0] ADDR_MAX   = 20'hFF,
  parameter int          FIFO_DEPTH = 16,
  parameter int          ALF_LEVEL  = 12,
  parameter logic [7:0]  RD_TIMEOUT = 8'd255
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        Command_in_wr,
  input  logic [63:0] Command_in,
  output logic        Command_in_alf,
  output logic        Command_out_wr,
  output logic [63:0] Command_out,
  input  logic        Command_out_alf,
  output logic        Reg_wr,
  output logic        Reg_rd,
  output logic [19:0] Reg_addr,
  output logic [31:0] Reg_wdata,
  input  logic [31:0] Reg_rdata,
  input  logic        Reg_rdata_valid,
  output logic [31:0] drop_cnt
`ifdef CMD_REG_ACCESS_STAT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] fwd_cnt,
  output logic [31:0] fail_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] ALF_LVL = ALF_LEVEL[AW:0];

  logic [CMD_W-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_full;
  logic [AW:0]      fifo_used;
  logic             fifo_pop;

  state_e           state_reg, state_next;
  logic [CMD_W-1:0] cmd_reg, cmd_next;
  logic [CMD_W-1:0] result_reg, result_next;
  logic [7:0]       timer_reg, timer_next;
  logic             reg_wr_reg, reg_wr_next;
  logic             reg_rd_reg, reg_rd_next;
  logic [19:0]      reg_addr_reg, reg_addr_next;
  logic [31:0]      reg_wdata_reg, reg_wdata_next;
  logic             local_reg, local_next;
  logic [31:0]      drop_cnt_reg;
  logic             cmd_out_wr;

  cmd_fifo_fwft #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Reset_N),
    .wr_en   (Command_in_wr),
    .wr_data (Command_in),
    .rd_en   (fifo_pop),
    .rd_data (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .used    (fifo_used)
  );

  assign Command_in_alf = (fifo_used >= ALF_LVL);
  assign Command_out_wr = cmd_out_wr;
  assign Command_out    = result_reg;
  assign Reg_wr         = reg_wr_reg;
  assign Reg_rd         = reg_rd_reg;
  assign Reg_addr       = reg_addr_reg;
  assign Reg_wdata      = reg_wdata_reg;
  assign drop_cnt       = drop_cnt_reg;

  // Count words offered while the FIFO is full (they are lost)
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N)                      drop_cnt_reg <= '0;
    else if (Command_in_wr && fifo_full) drop_cnt_reg <= drop_cnt_reg + 32'd1;
  end

  // FSM and datapath registers
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_reg     <= ST_IDLE;
      cmd_reg       <= '0;
      result_reg    <= '0;
      timer_reg     <= '0;
      reg_wr_reg    <= 1'b0;
      reg_rd_reg    <= 1'b0;
      reg_addr_reg  <= '0;
      reg_wdata_reg <= '0;
      local_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_reg       <= cmd_next;
      result_reg    <= result_next;
      timer_reg     <= timer_next;
      reg_wr_reg    <= reg_wr_next;
      reg_rd_reg    <= reg_rd_next;
      reg_addr_reg  <= reg_addr_next;
      reg_wdata_reg <= reg_wdata_next;
      local_reg     <= local_next;
    end
  end

  // Next-state logic: fetch, decode/execute, wait for read data, emit
  always_comb begin
    state_next     = state_reg;
    cmd_next       = cmd_reg;
    result_next    = result_reg;
    timer_next     = timer_reg;
    reg_wr_next    = 1'b0;
    reg_rd_next    = 1'b0;
    reg_addr_next  = reg_addr_reg;
    reg_wdata_next = reg_wdata_reg;
    local_next     = local_reg;
    fifo_pop       = 1'b0;
    cmd_out_wr     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Downstream back-pressure is only honoured here, between commands
        if (!fifo_empty && !Command_out_alf) begin
          cmd_next   = fifo_dout;
          fifo_pop   = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_next = cmd_reg;
        local_next  = 1'b1;
        if (cmd_reg[MDID_HI:MDID_LO] != MDID) begin
          local_next = 1'b0;
          state_next = ST_SEND;
        end else if (cmd_reg[ADDR_HI:ADDR_LO] > ADDR_MAX) begin
          result_next[SUCC_BIT] = 1'b0;
          state_next            = ST_SEND;
        end else if (cmd_reg[WR_BIT]) begin
          reg_wr_next           = 1'b1;
          reg_addr_next         = cmd_reg[ADDR_HI:ADDR_LO];
          reg_wdata_next        = cmd_reg[DATA_HI:DATA_LO];
          result_next[SUCC_BIT] = 1'b1;
          state_next            = ST_SEND;
        end else begin
          reg_rd_next   = 1'b1;
          reg_addr_next = cmd_reg[ADDR_HI:ADDR_LO];
          timer_next    = '0;
          state_next    = ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        // Data arriving on the final timeout cycle still counts as success
        if (Reg_rdata_valid) begin
          result_next[DATA_HI:DATA_LO] = Reg_rdata;
          result_next[SUCC_BIT]        = 1'b1;
          state_next                   = ST_SEND;
        end else if (timer_reg == RD_TIMEOUT) begin
          result_next[DATA_HI:DATA_LO] = '0;
          result_next[SUCC_BIT]        = 1'b0;
          state_next                   = ST_SEND;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      ST_SEND: begin
        cmd_out_wr = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef CMD_REG_ACCESS_STAT_EN
  logic [31:0] hit_cnt_reg, fwd_cnt_reg, fail_cnt_reg;

  assign hit_cnt  = hit_cnt_reg;
  assign fwd_cnt  = fwd_cnt_reg;
  assign fail_cnt = fail_cnt_reg;

  // Classify each emitted command once, in its SEND cycle
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      hit_cnt_reg  <= '0;
      fwd_cnt_reg  <= '0;
      fail_cnt_reg <= '0;
    end else if (state_reg == ST_SEND) begin
      if (!local_reg)                fwd_cnt_reg  <= fwd_cnt_reg + 32'd1;
      else if (result_reg[SUCC_BIT]) hit_cnt_reg  <= hit_cnt_reg + 32'd1;
      else                           fail_cnt_reg <= fail_cnt_reg + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmd_reg_access.sv
// Testbench for cmd_reg_access: directed cases plus randomized commands.
// Expected results come from a command-level model and are queued; monitors
// compare outputs and register-bus activity as they appear.
module tb_cmd_reg_access;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        Command_in_wr;
  logic [63:0] Command_in;
  logic        Command_in_alf;
  logic        Command_out_wr;
  logic [63:0] Command_out;
  logic        Command_out_alf;
  logic        Reg_wr;
  logic        Reg_rd;
  logic [19:0] Reg_addr;
  logic [31:0] Reg_wdata;
  logic [31:0] Reg_rdata;
  logic        Reg_rdata_valid;
  logic [31:0] drop_cnt;
`ifdef CMD_REG_ACCESS_STAT_EN
  logic [31:0] hit_cnt, fwd_cnt, fail_cnt;
  int hit_m = 0, fwd_m = 0, fail_m = 0;
`endif

  always #5 Clk = ~Clk;

  cmd_reg_access dut (
    .Clk             (Clk),
    .Reset_N         (Reset_N),
    .Command_in_wr   (Command_in_wr),
    .Command_in      (Command_in),
    .Command_in_alf  (Command_in_alf),
    .Command_out_wr  (Command_out_wr),
    .Command_out     (Command_out),
    .Command_out_alf (Command_out_alf),
    .Reg_wr          (Reg_wr),
    .Reg_rd          (Reg_rd),
    .Reg_addr        (Reg_addr),
    .Reg_wdata       (Reg_wdata),
    .Reg_rdata       (Reg_rdata),
    .Reg_rdata_valid (Reg_rdata_valid),
    .drop_cnt        (drop_cnt)
`ifdef CMD_REG_ACCESS_STAT_EN
    ,
    .hit_cnt         (hit_cnt),
    .fwd_cnt         (fwd_cnt),
    .fail_cnt        (fail_cnt)
`endif
  );

  // Scoreboard queues: results, bus accesses ({wr, addr, wdata}), read plans
  logic [63:0] exp_q[$];
  logic [52:0] bus_q[$];
  int          plan_delay_q[$];
  logic [31:0] plan_data_q[$];

  int n_vec = 0;
  int n_err = 0;
  int out_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Model: derive the result of one command from the command rules.
  // delay = cycles from the Reg_rd cycle to Reg_rdata_valid (-1: never).
  task automatic expect_cmd(input logic [63:0] c, input int delay, input logic [31:0] rdata);
    logic [63:0] r;
    r = c;
    if (c[58:52] != 7'd1) begin
`ifdef CMD_REG_ACCESS_STAT_EN
      fwd_m++;
`endif
    end else if (c[51:32] > 20'hFF) begin
      r[60] = 1'b0;
`ifdef CMD_REG_ACCESS_STAT_EN
      fail_m++;
`endif
    end else if (c[59]) begin
      r[60] = 1'b1;
      bus_q.push_back({1'b1, c[51:32], c[31:0]});
`ifdef CMD_REG_ACCESS_STAT_EN
      hit_m++;
`endif
    end else begin
      bus_q.push_back({1'b0, c[51:32], 32'h0});
      plan_delay_q.push_back(delay);
      plan_data_q.push_back(rdata);
      if (delay >= 0 && delay <= 255) begin
        r[31:0] = rdata;
        r[60]   = 1'b1;
`ifdef CMD_REG_ACCESS_STAT_EN
        hit_m++;
`endif
      end else begin
        r[31:0] = 32'h0;
        r[60]   = 1'b0;
`ifdef CMD_REG_ACCESS_STAT_EN
        fail_m++;
`endif
      end
    end
    exp_q.push_back(r);
  endtask

  task automatic send(input logic [63:0] c, input int delay, input logic [31:0] rdata);
    expect_cmd(c, delay, rdata);
    @(negedge Clk);
    Command_in_wr = 1'b1;
    Command_in    = c;
    @(negedge Clk);
    Command_in_wr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 5000) begin
      @(negedge Clk);
      n++;
    end
    check({name, "_results_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_bus_left"}, 64'(bus_q.size()), 64'd0);
    repeat (2) @(negedge Clk);
  endtask

  // Output monitor: every emitted command must match the next expectation
  initial begin
    forever begin
      @(negedge Clk);
      if (Command_out_wr === 1'b1) begin
        out_count++;
        $display("out %0d: %h", out_count, Command_out);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL out_unexpected: got %h, expected no output", Command_out);
        end else begin
          check("cmd_out", Command_out, exp_q.pop_front());
        end
      end
    end
  end

  // Bus monitor: each write/read pulse must match the next expected access
  initial begin
    logic [52:0] e;
    forever begin
      @(negedge Clk);
      if (Reg_wr === 1'b1 || Reg_rd === 1'b1) begin
        if (bus_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL bus_unexpected: got wr=%b rd=%b addr=%h, expected no access", Reg_wr, Reg_rd, Reg_addr);
        end else begin
          e = bus_q.pop_front();
          check("bus_kind", 64'({Reg_wr, Reg_rd}), e[52] ? 64'd2 : 64'd1);
          check("bus_addr", 64'(Reg_addr), 64'(e[51:32]));
          if (e[52]) check("bus_wdata", 64'(Reg_wdata), 64'(e[31:0]));
        end
      end
    end
  end

  // Register-bus slave: answers each read according to its plan
  initial begin
    int d;
    logic [31:0] dv;
    Reg_rdata_valid = 1'b0;
    Reg_rdata       = 32'h0;
    forever begin
      @(negedge Clk);
      if (Reg_rd === 1'b1 && plan_delay_q.size() != 0) begin
        d  = plan_delay_q.pop_front();
        dv = plan_data_q.pop_front();
        if (d >= 0) begin
          repeat (d) @(negedge Clk);
          Reg_rdata_valid = 1'b1;
          Reg_rdata       = dv;
          @(negedge Clk);
          Reg_rdata_valid = 1'b0;
          Reg_rdata       = $urandom();
        end
      end
    end
  end

  // Hard stop in case something never completes
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] c;
    logic [2:0]  typ;
    logic [6:0]  mdid;
    logic [19:0] addr;
    int          n, d, r, snap;

    Reset_N         = 1'b0;
    Command_in_wr   = 1'b0;
    Command_in      = 64'h0;
    Command_out_alf = 1'b0;
    repeat (3) @(negedge Clk);

    // Reset state
    check("rst_out_wr", 64'(Command_out_wr), 64'd0);
    check("rst_out", Command_out, 64'd0);
    check("rst_reg_wr", 64'(Reg_wr), 64'd0);
    check("rst_reg_rd", 64'(Reg_rd), 64'd0);
    check("rst_reg_addr", 64'(Reg_addr), 64'd0);
    check("rst_reg_wdata", 64'(Reg_wdata), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_in_alf", 64'(Command_in_alf), 64'd0);
    Reset_N = 1'b1;
    @(negedge Clk);

    // 1: local write, with 2-cycle latency from head visible to output
    send({3'b100, 1'b0, 1'b1, 7'd1, 20'h10, 32'hA5A5A5A5}, 0, 32'h0);
    @(negedge Clk);
    check("t1_latency_early", 64'(Command_out_wr), 64'd0);
    @(negedge Clk);
    check("t1_latency", 64'(Command_out_wr), 64'd1);
    drain("t1");

    // 2: local read answered 5 cycles after Reg_rd
    send({3'b100, 1'b0, 1'b0, 7'd1, 20'h20, 32'h0}, 5, 32'h12345678);
    drain("t2");

    // 3: read timeouts: never answered, answered on the last cycle, one too late
    send({3'b101, 1'b1, 1'b0, 7'd1, 20'h30, 32'hFFFF0000}, -1, 32'h0);
    drain("t3a");
    send({3'b111, 1'b0, 1'b0, 7'd1, 20'h31, 32'h0}, 255, 32'hDEADBEEF);
    drain("t3b");
    send({3'b110, 1'b0, 1'b0, 7'd1, 20'h32, 32'h0}, 256, 32'h0BADF00D);
    drain("t3c");

    // 4: forwarding and address range boundaries
    send({3'b111, 1'b1, 1'b1, 7'd5, 20'h10, 32'h01234567}, 0, 32'h0);
    send({3'b110, 1'b0, 1'b0, 7'd5, 20'h20, 32'h89ABCDEF}, 0, 32'h0);
    send({3'b100, 1'b1, 1'b1, 7'd1, 20'h100, 32'h11111111}, 0, 32'h0);
    send({3'b100, 1'b1, 1'b0, 7'd1, 20'h100, 32'h22222222}, 0, 32'h0);
    send({3'b100, 1'b0, 1'b1, 7'd1, 20'hFF, 32'h33333333}, 0, 32'h0);
    drain("t4");

    // Randomized commands with random downstream back-pressure
    for (int i = 0; i < 40; i++) begin
      Command_out_alf = ($urandom_range(0, 3) == 0);
      n = 0;
      while (Command_in_alf === 1'b1 && n < 5000) begin
        Command_out_alf = 1'b0;
        @(negedge Clk);
        n++;
      end
      case ($urandom_range(0, 3))
        0:       typ = 3'b101;
        1:       typ = 3'b111;
        2:       typ = 3'b110;
        default: typ = 3'b100;
      endcase
      mdid = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'd1;
      case ($urandom_range(0, 4))
        0:       addr = 20'($urandom());
        1:       addr = 20'hFF;
        2:       addr = 20'h100;
        default: addr = 20'($urandom_range(0, 255));
      endcase
      c = {typ, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mdid, addr, 32'($urandom())};
      r = int'($urandom_range(0, 19));
      d = (r == 0) ? 255 : (r == 1) ? 256 : (r == 2) ? -1 : int'($urandom_range(0, 8));
      send(c, d, 32'($urandom()));
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end
    Command_out_alf = 1'b0;
    drain("rand");

    // 5: burst of 20 with downstream almost full: 16 stored, 4 dropped
    Command_out_alf = 1'b1;
    @(negedge Clk);
    snap = out_count;
    for (int i = 0; i < 20; i++) begin
      check("t5_in_alf", 64'(Command_in_alf), 64'(i >= 12));
      c = {3'b101, 1'b0, 1'b1, (i % 2 == 1) ? 7'd5 : 7'd1, 20'(i), 32'($urandom())};
      if (i < 16) expect_cmd(c, 0, 32'h0);
      Command_in_wr = 1'b1;
      Command_in    = c;
      @(negedge Clk);
    end
    Command_in_wr = 1'b0;
    check("t5_in_alf_full", 64'(Command_in_alf), 64'd1);
    check("t5_drop_cnt", 64'(drop_cnt), 64'd4);
    repeat (5) @(negedge Clk);
    check("t5_held", 64'(out_count - snap), 64'd0);
    Command_out_alf = 1'b0;
    drain("t5");
    check("t5_emitted", 64'(out_count - snap), 64'd16);

    // 6: reset while waiting for read data aborts the command
    send({3'b100, 1'b0, 1'b0, 7'd1, 20'h44, 32'h0}, -1, 32'h0);
    n = 0;
    while (Reg_rd !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("t6_rd_seen", 64'(Reg_rd), 64'd1);
    repeat (3) @(negedge Clk);
    #2;
    Reset_N = 1'b0;
    exp_q.delete();
    bus_q.delete();
    plan_delay_q.delete();
    plan_data_q.delete();
`ifdef CMD_REG_ACCESS_STAT_EN
    hit_m = 0;
    fwd_m = 0;
    fail_m = 0;
`endif
    #1;
    check("t6_out_wr", 64'(Command_out_wr), 64'd0);
    check("t6_out", Command_out, 64'd0);
    check("t6_reg_rd", 64'(Reg_rd), 64'd0);
    check("t6_reg_addr", 64'(Reg_addr), 64'd0);
    check("t6_drop_cnt", 64'(drop_cnt), 64'd0);
    repeat (3) @(negedge Clk);
    Reset_N = 1'b1;
    @(negedge Clk);
    send({3'b100, 1'b0, 1'b1, 7'd1, 20'h55, 32'hCAFEF00D}, 0, 32'h0);
    drain("t6");

`ifdef CMD_REG_ACCESS_STAT_EN
    check("stat_hit", 64'(hit_cnt), 64'(hit_m));
    check("stat_fwd", 64'(fwd_cnt), 64'(fwd_m));
    check("stat_fail", 64'(fail_cnt), 64'(fail_m));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
